// File: rtl/nubus_pkg.sv
// rtl/nubus_pkg.sv - shared types and constants for the NuBus master sequencer
// Contents:
//   nub_state_e          sequencer state encoding
//   TM_OK/ERR/TMO/RETRY  completion status codes as returned on TM1/TM0 with ACK
//   LOCK_ATTN/NULL_ATTN  TM codes driven during attention cycles
package nubus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARB         = 3'd1,
    ST_LATTN       = 3'd2,
    ST_ADDR        = 3'd3,
    ST_DATA        = 3'd4,
    ST_DONE        = 3'd5,
    ST_LOCKED_IDLE = 3'd6,
    ST_NATTN       = 3'd7
  } nub_state_e;

  localparam logic [1:0] TM_OK    = 2'b00;
  localparam logic [1:0] TM_ERR   = 2'b01;
  localparam logic [1:0] TM_TMO   = 2'b10;
  localparam logic [1:0] TM_RETRY = 2'b11;

  localparam logic [1:0] LOCK_ATTN = 2'b01;
  localparam logic [1:0] NULL_ATTN = 2'b11;

endpackage

// File: rtl/nubus_master_seq_if.sv
// rtl/nubus_master_seq_if.sv - local-bus and NuBus pad signals of the master sequencer
// Signals:
//   cpu_req, cpu_write, cpu_lock, cpu_tm   local request (into the sequencer)
//   nub_arb_won, nub_start_i, nub_ack_i,
//   nub_tm_i                               sampled NuBus/arbiter state (into the sequencer)
//   nub_rqst_oe_o, nub_start_o, nub_ack_o,
//   nub_tm_o, nub_ctl_oe_o, nub_ad_oe_o    pad drives (from the sequencer)
//   cpu_done_o, cpu_status_o, cpu_err_o    completion report (from the sequencer)
// Modports: master = sequencer side, slave = card/pad-ring side.
interface nubus_master_seq_if;

  logic       cpu_req;
  logic       cpu_write;
  logic       cpu_lock;
  logic [1:0] cpu_tm;
  logic       nub_arb_won;
  logic       nub_start_i;
  logic       nub_ack_i;
  logic [1:0] nub_tm_i;

  logic       nub_rqst_oe_o;
  logic       nub_start_o;
  logic       nub_ack_o;
  logic [1:0] nub_tm_o;
  logic       nub_ctl_oe_o;
  logic       nub_ad_oe_o;
  logic       cpu_done_o;
  logic [1:0] cpu_status_o;
  logic       cpu_err_o;

  modport master (
    input  cpu_req, cpu_write, cpu_lock, cpu_tm,
    input  nub_arb_won, nub_start_i, nub_ack_i, nub_tm_i,
    output nub_rqst_oe_o, nub_start_o, nub_ack_o, nub_tm_o,
    output nub_ctl_oe_o, nub_ad_oe_o,
    output cpu_done_o, cpu_status_o, cpu_err_o
  );

  modport slave (
    output cpu_req, cpu_write, cpu_lock, cpu_tm,
    output nub_arb_won, nub_start_i, nub_ack_i, nub_tm_i,
    input  nub_rqst_oe_o, nub_start_o, nub_ack_o, nub_tm_o,
    input  nub_ctl_oe_o, nub_ad_oe_o,
    input  cpu_done_o, cpu_status_o, cpu_err_o
  );

endinterface

// File: rtl/nubus_bus_monitor.sv
// rtl/nubus_bus_monitor.sv - tracks whether another master owns a NuBus transaction
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   start, ack    sampled START / ACK, active-high
//   own_start     this card is driving START in the current cycle
//   busy          a foreign transaction is between its START and its ACK
module nubus_bus_monitor (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic ack,
  input  logic own_start,
  output logic busy
);

  // ACK ends any transaction; an attention cycle carries START and ACK
  // together, so the ACK check first also keeps ATTN cycles from setting busy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy <= 1'b0;
    end else if (ack) begin
      busy <= 1'b0;
    end else if (start && !own_start) begin
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/nubus_master_seq.sv
// rtl/nubus_master_seq.sv - registered NuBus master cycle sequencer
// Parameters:
//   RETRY_MAX   re-arbitrations allowed after TRY-AGAIN-LATER (0 = none)
//   TIMEOUT     DATA cycles without ACK before a local abort
// Ports:
//   nub_clkn    NuBus clock, rising-edge
//   nub_resetn  synchronous active-low reset
//   bus         nubus_master_seq_if.master: local request, sampled bus, pad drives, completion
// Build option: NUBUS_TIMEOUT_EN adds the DATA-phase no-ACK timeout counter.
module nubus_master_seq
  import nubus_pkg::*;
#(
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic               nub_clkn,
  input  logic               nub_resetn,
  nubus_master_seq_if.master bus
);

  localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  nub_state_e         state_q, state_d;
  logic               write_q, lock_q;
  logic [1:0]         tm_q;
  logic [1:0]         status_q, status_d;
  logic [RETRY_W-1:0] retry_cnt;
  logic               load_req, load_next, retry_inc;
  logic               busy, tmo_hit, tmo_abort_q;

  logic       rqst_drv, start_drv, ack_drv, ctl_drv, ad_drv, done_drv;
  logic [1:0] tm_drv;

  nubus_bus_monitor u_mon (
    .clk       (nub_clkn),
    .resetn    (nub_resetn),
    .start     (bus.nub_start_i),
    .ack       (bus.nub_ack_i),
    .own_start (start_drv),
    .busy      (busy)
  );

`ifdef NUBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Expires on the TIMEOUT-th DATA cycle without ACK; an ACK in that same
  // cycle masks it so the target's status is reported instead.
  assign tmo_hit = (state_q == ST_DATA) && !bus.nub_ack_i && (tmo_cnt == TMO_LAST);

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      tmo_cnt     <= '0;
      tmo_abort_q <= 1'b0;
    end else begin
      if (state_q == ST_DATA && !bus.nub_ack_i && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      // Remembers the abort through DONE so a locked sequence is closed with NULL-ATTN.
      if (tmo_hit) begin
        tmo_abort_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
        tmo_abort_q <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign tmo_abort_q    = 1'b0;
`endif

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    load_req  = 1'b0;
    load_next = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_d  = ST_ARB;
          load_req = 1'b1;
        end
      end
      ST_ARB: begin
        if (bus.nub_arb_won && !busy) begin
          state_d = lock_q ? ST_LATTN : ST_ADDR;
        end
      end
      ST_LATTN: state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_DATA;
      ST_DATA: begin
        if (bus.nub_ack_i) begin
          if (bus.nub_tm_i == TM_RETRY && retry_cnt < RETRY_LIM) begin
            // A locked sequence still owns the bus, so it skips arbitration.
            retry_inc = 1'b1;
            state_d   = lock_q ? ST_ADDR : ST_ARB;
          end else begin
            state_d  = ST_DONE;
            status_d = bus.nub_tm_i;
          end
        end else if (tmo_hit) begin
          state_d  = ST_DONE;
          status_d = TM_TMO;
        end
      end
      ST_DONE: begin
        if (!lock_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = tmo_abort_q ? ST_NATTN : ST_LOCKED_IDLE;
        end
      end
      ST_LOCKED_IDLE: begin
        if (!bus.cpu_lock) begin
          state_d = ST_NATTN;
        end else if (bus.cpu_req) begin
          state_d   = ST_ADDR;
          load_next = 1'b1;
        end
      end
      ST_NATTN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      write_q   <= 1'b0;
      lock_q    <= 1'b0;
      tm_q      <= 2'b00;
      status_q  <= TM_OK;
      retry_cnt <= '0;
    end else begin
      if (load_req) begin
        write_q <= bus.cpu_write;
        tm_q    <= bus.cpu_tm;
        lock_q  <= bus.cpu_lock;
      end else if (load_next) begin
        write_q <= bus.cpu_write;
        tm_q    <= bus.cpu_tm;
      end else if (state_d == ST_IDLE) begin
        lock_q <= 1'b0;
      end
      status_q <= status_d;
      if (state_d == ST_DONE) begin
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  // Pad drives decode from state and captured fields only. RQST stays asserted
  // across a whole locked sequence so no other master can slip in between.
  always_comb begin
    rqst_drv  = 1'b0;
    start_drv = 1'b0;
    ack_drv   = 1'b0;
    tm_drv    = 2'b00;
    ctl_drv   = 1'b0;
    ad_drv    = 1'b0;
    done_drv  = 1'b0;
    case (state_q)
      ST_ARB: rqst_drv = 1'b1;
      ST_LATTN: begin
        rqst_drv  = 1'b1;
        start_drv = 1'b1;
        ack_drv   = 1'b1;
        tm_drv    = LOCK_ATTN;
        ctl_drv   = 1'b1;
      end
      ST_ADDR: begin
        rqst_drv  = lock_q;
        start_drv = 1'b1;
        tm_drv    = tm_q;
        ctl_drv   = 1'b1;
        ad_drv    = 1'b1;
      end
      ST_DATA: begin
        rqst_drv = lock_q;
        ad_drv   = write_q;
      end
      ST_DONE: begin
        rqst_drv = lock_q;
        done_drv = 1'b1;
      end
      ST_LOCKED_IDLE: rqst_drv = 1'b1;
      ST_NATTN: begin
        rqst_drv  = 1'b1;
        start_drv = 1'b1;
        ack_drv   = 1'b1;
        tm_drv    = NULL_ATTN;
        ctl_drv   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.nub_rqst_oe_o = rqst_drv;
  assign bus.nub_start_o   = start_drv;
  assign bus.nub_ack_o     = ack_drv;
  assign bus.nub_tm_o      = tm_drv;
  assign bus.nub_ctl_oe_o  = ctl_drv;
  assign bus.nub_ad_oe_o   = ad_drv;
  assign bus.cpu_done_o    = done_drv;
  assign bus.cpu_status_o  = status_q;
  assign bus.cpu_err_o     = (status_q != TM_OK);

endmodule
